// File: rtl/tcp_hs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tcp_hs_pkg                                                      |
// | Purpose  : Shared state encoding, flag masks and sequence helpers for the  |
// |            TCP handshake endpoint.                                         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package tcp_hs_pkg;

    typedef enum logic [2:0] {
        ST_CLOSED      = 3'd0,
        ST_LISTEN      = 3'd1,
        ST_SYN_SENT    = 3'd2,
        ST_SYN_RCVD    = 3'd3,
        ST_ESTABLISHED = 3'd4,
        ST_FAILED      = 3'd5
    } tcp_hs_state_e;

    // Bit positions follow the TCP header flag byte.
    localparam int FLAG_SYN = 1;
    localparam int FLAG_ACK = 4;

    localparam logic [7:0] HS_SYN     = 8'(1 << FLAG_SYN);
    localparam logic [7:0] HS_ACK     = 8'(1 << FLAG_ACK);
    localparam logic [7:0] HS_SYN_ACK = HS_SYN | HS_ACK;
    localparam logic [7:0] HS_MASK    = HS_SYN | HS_ACK;

    function automatic logic [63:0] seq_inc(input logic [63:0] v, input int w);
        logic [63:0] mask;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v + 64'd1) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tcp_hs_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tcp_hs_timer                                                    |
// | Purpose  : Loadable handshake timeout counter with a one-cycle expiry      |
// |            pulse when the count reaches TIMEOUT_CYC-1.                     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tcp_hs_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYC - 1);

    if (TIMEOUT_CYC < 2) begin : g_timeout_check
        $error("TIMEOUT_CYC must be at least 2");
    end

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expired = enable && !load && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/tcp_hs_endpoint.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tcp_hs_endpoint                                                 |
// | Purpose  : TCP three-way-handshake endpoint (client or server role) with   |
// |            valid/ready segment ports, timeout and abort. Define            |
// |            TCP_HS_RETRY_EN to retransmit on timeout up to MAX_RETRY times. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tcp_hs_endpoint
    import tcp_hs_pkg::*;
#(
    parameter int SEQ_W       = 32,
    parameter int ROLE        = 0,
    parameter int TIMEOUT_CYC = 1000,
    parameter int MAX_RETRY   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             open_i,
    input  logic             abort_i,
    input  logic [SEQ_W-1:0] isn_i,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic             rx_syn,
    input  logic             rx_ack,
    input  logic [SEQ_W-1:0] rx_seq,
    input  logic [SEQ_W-1:0] rx_ackno,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_syn,
    output logic             tx_ack,
    output logic [SEQ_W-1:0] tx_seq,
    output logic [SEQ_W-1:0] tx_ackno,
    output logic [2:0]       state_o,
    output logic             established,
    output logic             failed
);

    localparam bit C_IS_CLIENT = (ROLE == 0);

    if (SEQ_W < 1 || SEQ_W > 64 || MAX_RETRY < 0) begin : g_param_check
        $error("SEQ_W must be 1..64 and MAX_RETRY non-negative");
    end

    tcp_hs_state_e    r_state;
    logic [SEQ_W-1:0] r_iss, r_irs, r_tx_seq, r_tx_ackno;
    logic             r_tx_valid, r_tx_syn, r_tx_ack, r_established, r_failed;

    logic [7:0]       w_rx_flags, w_rx_hs;
    logic [SEQ_W-1:0] w_iss_next, w_irs_next, w_rx_seq_next;
    logic             w_rx_fire, w_open_acc, w_listen_match, w_sent_match, w_rcvd_match;
    logic             w_rx_match, w_timer_en, w_timer_load, w_timeout;
    logic             w_retry_exhausted, w_retransmit;

    always_comb begin
        w_rx_flags           = '0;
        w_rx_flags[FLAG_SYN] = rx_syn;
        w_rx_flags[FLAG_ACK] = rx_ack;
    end

    assign w_rx_hs       = w_rx_flags & HS_MASK;
    assign w_iss_next    = SEQ_W'(seq_inc(64'(r_iss), SEQ_W));
    assign w_irs_next    = SEQ_W'(seq_inc(64'(r_irs), SEQ_W));
    assign w_rx_seq_next = SEQ_W'(seq_inc(64'(rx_seq), SEQ_W));

    assign w_rx_fire      = rx_valid && !r_tx_valid;
    assign w_open_acc     = open_i && !abort_i && (r_state == ST_CLOSED);
    assign w_listen_match = w_rx_fire && (r_state == ST_LISTEN) && (w_rx_hs == HS_SYN);
    assign w_sent_match   = w_rx_fire && (r_state == ST_SYN_SENT) && (w_rx_hs == HS_SYN_ACK)
                            && (rx_ackno == w_iss_next);
    assign w_rcvd_match   = w_rx_fire && (r_state == ST_SYN_RCVD) && (w_rx_hs == HS_ACK)
                            && (rx_ackno == w_iss_next);
    assign w_rx_match     = w_listen_match || w_sent_match || w_rcvd_match;

    // The timer only runs while the last segment has actually left.
    assign w_timer_en   = ((r_state == ST_SYN_SENT) || (r_state == ST_SYN_RCVD)) && !r_tx_valid;
    assign w_retransmit = w_timeout && !w_rx_match && !w_retry_exhausted && !abort_i;
    assign w_timer_load = abort_i || w_open_acc || w_listen_match || w_retransmit;

    tcp_hs_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (w_timer_load),
        .enable  (w_timer_en),
        .expired (w_timeout)
    );

`ifdef TCP_HS_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RETRY_W-1:0] r_retry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retry <= '0;
        end else if (abort_i || w_open_acc || w_listen_match) begin
            r_retry <= '0;
        end else if (w_retransmit) begin
            r_retry <= r_retry + RETRY_W'(1);
        end
    end

    assign w_retry_exhausted = (r_retry == RETRY_W'(MAX_RETRY));
`else
    assign w_retry_exhausted = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_CLOSED;
            r_iss         <= '0;
            r_irs         <= '0;
            r_tx_valid    <= 1'b0;
            r_tx_syn      <= 1'b0;
            r_tx_ack      <= 1'b0;
            r_tx_seq      <= '0;
            r_tx_ackno    <= '0;
            r_established <= 1'b0;
            r_failed      <= 1'b0;
        end else if (abort_i) begin
            r_state       <= ST_CLOSED;
            r_tx_valid    <= 1'b0;
            r_established <= 1'b0;
            r_failed      <= 1'b0;
        end else begin
            if (r_tx_valid && tx_ready) begin
                r_tx_valid <= 1'b0;
            end
            case (r_state)
                ST_CLOSED: begin
                    if (open_i) begin
                        r_iss <= isn_i;
                        if (C_IS_CLIENT) begin
                            r_state    <= ST_SYN_SENT;
                            r_tx_valid <= 1'b1;
                            r_tx_syn   <= 1'b1;
                            r_tx_ack   <= 1'b0;
                            r_tx_seq   <= isn_i;
                            r_tx_ackno <= '0;
                        end else begin
                            r_state <= ST_LISTEN;
                        end
                    end
                end
                ST_LISTEN: begin
                    if (w_listen_match) begin
                        r_irs      <= rx_seq;
                        r_state    <= ST_SYN_RCVD;
                        r_tx_valid <= 1'b1;
                        r_tx_syn   <= 1'b1;
                        r_tx_ack   <= 1'b1;
                        r_tx_seq   <= r_iss;
                        r_tx_ackno <= w_rx_seq_next;
                    end
                end
                ST_SYN_SENT: begin
                    if (w_sent_match) begin
                        r_irs         <= rx_seq;
                        r_state       <= ST_ESTABLISHED;
                        r_established <= 1'b1;
                        r_tx_valid    <= 1'b1;
                        r_tx_syn      <= 1'b0;
                        r_tx_ack      <= 1'b1;
                        r_tx_seq      <= w_iss_next;
                        r_tx_ackno    <= w_rx_seq_next;
                    end else if (w_timeout) begin
                        if (w_retry_exhausted) begin
                            r_state  <= ST_FAILED;
                            r_failed <= 1'b1;
                        end else begin
                            r_tx_valid <= 1'b1;
                            r_tx_syn   <= 1'b1;
                            r_tx_ack   <= 1'b0;
                            r_tx_seq   <= r_iss;
                            r_tx_ackno <= '0;
                        end
                    end
                end
                ST_SYN_RCVD: begin
                    if (w_rcvd_match) begin
                        r_state       <= ST_ESTABLISHED;
                        r_established <= 1'b1;
                    end else if (w_timeout) begin
                        if (w_retry_exhausted) begin
                            r_state  <= ST_FAILED;
                            r_failed <= 1'b1;
                        end else begin
                            r_tx_valid <= 1'b1;
                            r_tx_syn   <= 1'b1;
                            r_tx_ack   <= 1'b1;
                            r_tx_seq   <= r_iss;
                            r_tx_ackno <= w_irs_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rx_ready    = !r_tx_valid;
    assign tx_valid    = r_tx_valid;
    assign tx_syn      = r_tx_syn;
    assign tx_ack      = r_tx_ack;
    assign tx_seq      = r_tx_seq;
    assign tx_ackno    = r_tx_ackno;
    assign state_o     = r_state;
    assign established = r_established;
    assign failed      = r_failed;

endmodule
`default_nettype wire

// File: tb/tb_tcp_hs_endpoint.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_tcp_hs_endpoint                                              |
// | Purpose  : Self-checking bench for tcp_hs_endpoint, client and server role.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_tcp_hs_endpoint;

    typedef struct packed {
        logic        syn;
        logic        ack;
        logic [31:0] seq;
        logic [31:0] ackno;
    } seg_t;

`ifdef TCP_HS_RETRY_EN
    localparam int EXP_RETRIES = 2;
`else
    localparam int EXP_RETRIES = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        c_open, c_abort, c_rx_valid, c_rx_ready, c_rx_syn, c_rx_ack;
    logic [31:0] c_isn, c_rx_seq, c_rx_ackno, c_tx_seq, c_tx_ackno;
    logic        c_tx_valid, c_tx_ready, c_tx_syn, c_tx_ack, c_est, c_failed;
    logic [2:0]  c_state;

    logic        s_open, s_abort, s_rx_valid, s_rx_ready, s_rx_syn, s_rx_ack;
    logic [31:0] s_isn, s_rx_seq, s_rx_ackno, s_tx_seq, s_tx_ackno;
    logic        s_tx_valid, s_tx_ready, s_tx_syn, s_tx_ack, s_est, s_failed;
    logic [2:0]  s_state;

    tcp_hs_endpoint #(.SEQ_W(32), .ROLE(0), .TIMEOUT_CYC(16), .MAX_RETRY(2)) u_client (
        .clk(clk), .reset(reset), .open_i(c_open), .abort_i(c_abort), .isn_i(c_isn),
        .rx_valid(c_rx_valid), .rx_ready(c_rx_ready), .rx_syn(c_rx_syn), .rx_ack(c_rx_ack),
        .rx_seq(c_rx_seq), .rx_ackno(c_rx_ackno), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready),
        .tx_syn(c_tx_syn), .tx_ack(c_tx_ack), .tx_seq(c_tx_seq), .tx_ackno(c_tx_ackno),
        .state_o(c_state), .established(c_est), .failed(c_failed)
    );

    tcp_hs_endpoint #(.SEQ_W(32), .ROLE(1), .TIMEOUT_CYC(16), .MAX_RETRY(2)) u_server (
        .clk(clk), .reset(reset), .open_i(s_open), .abort_i(s_abort), .isn_i(s_isn),
        .rx_valid(s_rx_valid), .rx_ready(s_rx_ready), .rx_syn(s_rx_syn), .rx_ack(s_rx_ack),
        .rx_seq(s_rx_seq), .rx_ackno(s_rx_ackno), .tx_valid(s_tx_valid), .tx_ready(s_tx_ready),
        .tx_syn(s_tx_syn), .tx_ack(s_tx_ack), .tx_seq(s_tx_seq), .tx_ackno(s_tx_ackno),
        .state_o(s_state), .established(s_est), .failed(s_failed)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    seg_t exp_c[$];
    seg_t exp_s[$];
    seg_t got_c, got_s, want_c, want_s;

    // Scoreboards: a segment leaves on the next rising edge when valid & ready.
    always @(negedge clk) begin
        if (!reset && c_tx_valid && c_tx_ready) begin
            got_c = {c_tx_syn, c_tx_ack, c_tx_seq, c_tx_ackno};
            n_checks++;
            if (exp_c.size() == 0) begin
                n_fail++;
                $display("FAIL client_tx unexpected segment got=%h required=none", got_c);
            end else begin
                want_c = exp_c.pop_front();
                if (got_c !== want_c) begin
                    n_fail++;
                    $display("FAIL client_tx got=%h required=%h", got_c, want_c);
                end
            end
        end
        if (!reset && s_tx_valid && s_tx_ready) begin
            got_s = {s_tx_syn, s_tx_ack, s_tx_seq, s_tx_ackno};
            n_checks++;
            if (exp_s.size() == 0) begin
                n_fail++;
                $display("FAIL server_tx unexpected segment got=%h required=none", got_s);
            end else begin
                want_s = exp_s.pop_front();
                if (got_s !== want_s) begin
                    n_fail++;
                    $display("FAIL server_tx got=%h required=%h", got_s, want_s);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c_open = 0; c_abort = 0; c_isn = '0; c_rx_valid = 0; c_rx_syn = 0; c_rx_ack = 0;
        c_rx_seq = '0; c_rx_ackno = '0; c_tx_ready = 1;
        s_open = 0; s_abort = 0; s_isn = '0; s_rx_valid = 0; s_rx_syn = 0; s_rx_ack = 0;
        s_rx_seq = '0; s_rx_ackno = '0; s_tx_ready = 1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        exp_c.delete();
        exp_s.delete();
    endtask

    task automatic send_rx(input bit srv, input bit syn, input bit ack,
                           input logic [31:0] seq, input logic [31:0] ackno);
        bit ok = 0;
        if (srv) begin
            s_rx_valid = 1; s_rx_syn = syn; s_rx_ack = ack; s_rx_seq = seq; s_rx_ackno = ackno;
        end else begin
            c_rx_valid = 1; c_rx_syn = syn; c_rx_ack = ack; c_rx_seq = seq; c_rx_ackno = ackno;
        end
        for (int i = 0; i < 40; i++) begin
            if ((srv ? s_rx_ready : c_rx_ready) === 1'b1) begin
                ok = 1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rx_ready_timeout srv=%0b rx_ready=0 required=1", srv);
        end
        tick();
        s_rx_valid = 0;
        c_rx_valid = 0;
    endtask

    task automatic wait_drain(input bit srv);
        for (int i = 0; i < 40; i++) begin
            if ((srv ? exp_s.size() : exp_c.size()) == 0) break;
            tick();
        end
        n_checks++;
        if ((srv ? exp_s.size() : exp_c.size()) != 0) begin
            n_fail++;
            $display("FAIL tx_drain srv=%0b pending=%0d required=0", srv,
                     srv ? exp_s.size() : exp_c.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (c_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d required=0", c_state); end
        n_checks++;
        if ({c_tx_valid, c_tx_syn, c_tx_ack, c_est, c_failed} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags got=%b required=00000", {c_tx_valid, c_tx_syn, c_tx_ack, c_est, c_failed});
        end
        n_checks++;
        if ({c_tx_seq, c_tx_ackno} !== 64'd0) begin
            n_fail++; $display("FAIL reset_seq got=%h required=0", {c_tx_seq, c_tx_ackno});
        end
        n_checks++;
        if ({s_state, s_tx_valid, s_est, s_failed, s_tx_seq, s_tx_ackno} !== '0 || s_rx_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_server state=%0d tx_valid=%0b rx_ready=%0b required 0/0/1", s_state, s_tx_valid, s_rx_ready);
        end
    endtask

    task automatic test_client_handshake();
        do_reset();
        c_isn = 32'h1000;
        exp_c.push_back('{syn: 1'b1, ack: 1'b0, seq: 32'h1000, ackno: 32'h0});
        c_open = 1; tick(); c_open = 0;
        n_checks++;
        if (c_state !== 3'd2 || c_tx_valid !== 1'b1) begin
            n_fail++; $display("FAIL client_syn_sent state=%0d tx_valid=%0b required 2/1", c_state, c_tx_valid);
        end
        wait_drain(0);
        exp_c.push_back('{syn: 1'b0, ack: 1'b1, seq: 32'h1001, ackno: 32'h5001});
        send_rx(0, 1, 1, 32'h5000, 32'h1001);
        n_checks++;
        if (c_state !== 3'd4 || c_est !== 1'b1) begin
            n_fail++; $display("FAIL client_established state=%0d est=%0b required 4/1", c_state, c_est);
        end
        wait_drain(0);
    endtask

    task automatic test_server_wrap();
        do_reset();
        s_isn = 32'hFFFF_FFFF;
        s_open = 1; tick(); s_open = 0;
        n_checks++;
        if (s_state !== 3'd1 || s_tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL server_listen state=%0d tx_valid=%0b required 1/0", s_state, s_tx_valid);
        end
        exp_s.push_back('{syn: 1'b1, ack: 1'b1, seq: 32'hFFFF_FFFF, ackno: 32'h23});
        send_rx(1, 1, 0, 32'h22, 32'h0);
        n_checks++;
        if (s_state !== 3'd3) begin
            n_fail++; $display("FAIL server_syn_rcvd state=%0d required 3", s_state);
        end
        wait_drain(1);
        send_rx(1, 0, 1, 32'h23, 32'h0);
        n_checks++;
        if (s_state !== 3'd4 || s_est !== 1'b1) begin
            n_fail++; $display("FAIL server_wrap_established state=%0d est=%0b required 4/1", s_state, s_est);
        end
    endtask

    task automatic test_wrong_ackno();
        do_reset();
        c_isn = 32'h1000;
        exp_c.push_back('{syn: 1'b1, ack: 1'b0, seq: 32'h1000, ackno: 32'h0});
        c_open = 1; tick(); c_open = 0;
        wait_drain(0);
        send_rx(0, 1, 1, 32'h5000, 32'h1005);
        n_checks++;
        if (c_state !== 3'd2 || c_est !== 1'b0 || c_tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL wrong_ackno_dropped state=%0d est=%0b tx_valid=%0b required 2/0/0", c_state, c_est, c_tx_valid);
        end
        exp_c.push_back('{syn: 1'b0, ack: 1'b1, seq: 32'h1001, ackno: 32'h5001});
        send_rx(0, 1, 1, 32'h5000, 32'h1001);
        n_checks++;
        if (c_state !== 3'd4) begin
            n_fail++; $display("FAIL wrong_ackno_recover state=%0d required 4", c_state);
        end
        wait_drain(0);
    endtask

    task automatic test_timeout();
        int n = 0;
        do_reset();
        c_isn = 32'hABCD_0000;
        for (int i = 0; i <= EXP_RETRIES; i++)
            exp_c.push_back('{syn: 1'b1, ack: 1'b0, seq: 32'hABCD_0000, ackno: 32'h0});
        c_open = 1; tick(); c_open = 0;
        // Each attempt: one cycle on tx plus 16 idle counting cycles.
        while (c_failed !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        n_checks++;
        if (c_failed !== 1'b1 || n != 17 * (EXP_RETRIES + 1)) begin
            n_fail++; $display("FAIL timeout_cycles got=%0d required=%0d", n, 17 * (EXP_RETRIES + 1));
        end
        n_checks++;
        if (c_state !== 3'd5 || exp_c.size() != 0) begin
            n_fail++; $display("FAIL timeout_failed_state state=%0d pending=%0d required 5/0", c_state, exp_c.size());
        end
        c_open = 1; tick(); c_open = 0;
        n_checks++;
        if (c_state !== 3'd5) begin
            n_fail++; $display("FAIL failed_ignores_open state=%0d required 5", c_state);
        end
        c_abort = 1; tick(); c_abort = 0;
        n_checks++;
        if (c_state !== 3'd0 || c_failed !== 1'b0) begin
            n_fail++; $display("FAIL failed_abort state=%0d failed=%0b required 0/0", c_state, c_failed);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        do_reset();
        c_tx_ready = 0;
        c_isn = 32'h0000_7777;
        exp_c.push_back('{syn: 1'b1, ack: 1'b0, seq: 32'h7777, ackno: 32'h0});
        c_open = 1; tick(); c_open = 0;
        for (int i = 0; i < 20; i++) begin
            if (c_tx_valid !== 1'b1 || c_tx_syn !== 1'b1 || c_tx_ack !== 1'b0 ||
                c_tx_seq !== 32'h7777 || c_tx_ackno !== 32'h0 || c_rx_ready !== 1'b0)
                bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL backpressure_stable bad_cycles=%0d required=0", bad);
        end
        n_checks++;
        if (c_state !== 3'd2 || c_failed !== 1'b0) begin
            n_fail++; $display("FAIL backpressure_timer_frozen state=%0d failed=%0b required 2/0", c_state, c_failed);
        end
        c_tx_ready = 1;
        tick();
        repeat (3) tick();
        n_checks++;
        if (c_tx_valid !== 1'b0 || exp_c.size() != 0) begin
            n_fail++; $display("FAIL backpressure_release tx_valid=%0b pending=%0d required 0/0", c_tx_valid, exp_c.size());
        end
        c_abort = 1; tick(); c_abort = 0;
    endtask

    task automatic test_abort_and_async_reset();
        do_reset();
        s_isn = 32'h100;
        s_open = 1; tick(); s_open = 0;
        s_tx_ready = 0;
        send_rx(1, 1, 0, 32'h40, 32'h0);
        n_checks++;
        if (s_state !== 3'd3 || s_tx_valid !== 1'b1) begin
            n_fail++; $display("FAIL abort_setup state=%0d tx_valid=%0b required 3/1", s_state, s_tx_valid);
        end
        s_abort = 1; tick(); s_abort = 0;
        n_checks++;
        if (s_state !== 3'd0 || s_tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_syn_rcvd state=%0d tx_valid=%0b required 0/0", s_state, s_tx_valid);
        end
        s_tx_ready = 1;
        c_tx_ready = 0;
        c_isn = 32'h1234;
        c_open = 1; tick(); c_open = 0;
        tick();
        #3;
        reset = 1;
        #1;
        n_checks++;
        if ({c_state, c_tx_valid, c_tx_syn, c_tx_ack, c_tx_seq, c_tx_ackno, c_est, c_failed} !== '0) begin
            n_fail++; $display("FAIL async_reset state=%0d tx_valid=%0b tx_seq=%h required all zero", c_state, c_tx_valid, c_tx_seq);
        end
        @(posedge clk);
        #1;
        reset = 0;
        idle_inputs();
        exp_c.delete();
        exp_s.delete();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_client_handshake();
        test_server_wrap();
        test_wrong_ackno();
        test_timeout();
        test_backpressure();
        test_abort_and_async_reset();
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
